eth_mac_tx: RTL and testbench
=============================

ETH_MAC_TX -- requirements
Module: eth_mac_tx

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum data+pad bytes per frame, excluding preamble/SFD/FCS.
REQ-002 Parameter IFG_BYTES, default 12, inter-frame gap in byte times (4 clocks each).
REQ-003 gmii_clk  input  1  sole clock, 50 MHz; all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  payload byte valid.
REQ-006 s_data  input  8  payload byte (caller supplies full MAC header + payload).
REQ-007 s_last  input  1  marks final payload byte of a frame.
REQ-008 s_ready  output  1  payload byte consumed this cycle when s_valid & s_ready.
REQ-009 gmii_txen  output  1  registered; held high for the whole frame, preamble through last FCS byte.
REQ-010 gmii_txdata  output  8  registered; current byte offered to the RMII converter.
REQ-011 gmii_txbusy  input  1  converter busy; byte accepted on any edge where gmii_txen & !gmii_txbusy ("accept").
REQ-012 tx_active  output  1  high from frame start until end of IFG.
REQ-013 tx_done  output  1  one-cycle pulse at accept of final FCS byte.
REQ-014 tx_underrun  output  1  one-cycle pulse when a payload byte is needed and s_valid is low.

Function
REQ-015 States: IDLE, PREAMBLE, DATA, PAD, FCS, DRAIN, IFG.
REQ-016 IDLE: when s_valid, set gmii_txen=1, gmii_txdata=0x55, byte counter=1, go PREAMBLE; s_ready stays low.
REQ-017 PREAMBLE: on each accept load next byte; 7 bytes of 0x55 then 0xD5 (SFD); accept of SFD loads first payload byte and enters DATA.
REQ-018 Payload load: s_ready = accept & (next byte is payload); gmii_txdata <= s_data on that edge; no combinational path from s_data to gmii outputs.
REQ-019 DATA: on accept, if last loaded byte carried s_last, go PAD when payload count < MIN_FRAME else go FCS; otherwise load next s_data.
REQ-020 PAD: load 0x00 on each accept until data+pad count equals MIN_FRAME, then FCS.
REQ-021 CRC-32: poly 0x04C11DB7, reflected, init 0xFFFFFFFF, updated with each data/pad byte at the edge it is loaded into gmii_txdata; preamble/SFD excluded.
REQ-022 FCS: four bytes ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] in that order, first loaded on accept of last data/pad byte.
REQ-023 Accept of 4th FCS byte: gmii_txen<=0, tx_done=1, go IFG.
REQ-024 IFG: count IFG_BYTES*4 clocks from cycle after last accept, then IDLE; s_ready low throughout.
REQ-025 Payload counter 11 bits, saturates at 2047; no maximum-length truncation.
REQ-026 Underrun: payload byte needed with s_valid low -> tx_underrun=1, gmii_txen<=0 same edge, go DRAIN.
REQ-027 DRAIN: s_ready=1, discard bytes until s_valid & s_last consumed, then IFG; tx_done not asserted.
REQ-028 With converter busy pattern, accepts occur every 4 clocks; gmii_txdata changes only on accept edges.
REQ-029 gmii_txbusy high while gmii_txen low is ignored; byte never re-sent or skipped.

Reset
REQ-030 sys_rst high at any edge: state IDLE, gmii_txen=0, gmii_txdata=0x00, s_ready=0, tx_active=0, tx_done=0, tx_underrun=0, CRC=0xFFFFFFFF, counters 0.
REQ-031 Reset mid-frame aborts immediately; no FCS, no IFG; next frame may start on first cycle after release.

Verification
REQ-032 60-byte payload 0x00..0x3B, converter busy model -> 72 accepts (7x0x55, 0xD5, payload, 4 FCS), one per 4 clocks, gmii_txen continuous, single tx_done.
REQ-033 1-byte payload 0xAB -> 0xAB then 59x0x00 pad, FCS over 60 bytes, 72 accepts total.
REQ-034 MIN_FRAME=1, payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB.
REQ-035 s_valid dropped before payload byte 10 -> tx_underrun pulse, gmii_txen low next cycle, rest of frame drained to s_last, no tx_done.
REQ-036 Two queued frames -> second 0x55 offered no earlier than 48 clocks after first frame's final FCS accept.
REQ-037 sys_rst pulsed during FCS byte 2 -> all outputs at reset values next cycle; new frame then transmits correctly.

Source files
------------

// File: rtl/eth_mac_tx_if.sv
// eth_mac_tx_if: byte-stream handshake carrying frame payload into the MAC.
//   s_valid : payload byte valid
//   s_data  : payload byte (MAC header + payload, no preamble/FCS)
//   s_last  : final payload byte of a frame
//   s_ready : byte consumed on an edge where s_valid & s_ready
// master = payload source, slave = eth_mac_tx.
interface eth_mac_tx_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/eth_mac_tx.sv
// eth_mac_tx: Ethernet transmit framer in front of a byte-wide RMII converter.
// Wraps a caller-supplied payload with preamble/SFD, zero padding up to
// MIN_FRAME bytes and a CRC-32 FCS, then holds an inter-frame gap.
//   gmii_clk    : sole clock, rising edge
//   sys_rst     : synchronous active-high reset
//   stream      : payload handshake (slave side)
//   gmii_txen   : high from preamble through last FCS byte
//   gmii_txdata : byte offered to the converter
//   gmii_txbusy : converter busy; a byte is accepted when txen & !busy
//   tx_active   : high from frame start to end of the gap
//   tx_done     : pulse on accept of the final FCS byte
//   tx_underrun : pulse when a payload byte is needed but not valid
module eth_mac_tx #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic        gmii_clk,
    input  logic        sys_rst,
    eth_mac_tx_if.slave stream,
    output logic        gmii_txen,
    output logic [7:0]  gmii_txdata,
    input  logic        gmii_txbusy,
    output logic        tx_active,
    output logic        tx_done,
    output logic        tx_underrun
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PAD      = 3'd3;
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);

    logic [2:0]  state;
    logic [3:0]  byte_cnt;     // preamble position, later FCS byte index
    logic [10:0] pay_cnt;      // data + pad bytes loaded, saturating
    logic [31:0] crc;
    logic        last_seen;    // byte currently offered carried s_last
    logic [15:0] ifg_cnt;

    logic        accept;
    logic        need_payload;
    logic [10:0] pay_cnt_inc;
    logic [7:0]  fcs_byte;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        accept       = gmii_txen & ~gmii_txbusy;
        // A payload byte is pulled only on the accept that frees the output
        // register, so s_data reaches gmii_txdata through a flop only.
        need_payload = accept & (((state == ST_PREAMBLE) && (byte_cnt == 4'd8)) ||
                                 ((state == ST_DATA) && !last_seen));
        stream.s_ready = need_payload | (state == ST_DRAIN);
        pay_cnt_inc  = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;
        case (byte_cnt[1:0])
            2'd0:    fcs_byte = ~crc[7:0];
            2'd1:    fcs_byte = ~crc[15:8];
            2'd2:    fcs_byte = ~crc[23:16];
            default: fcs_byte = ~crc[31:24];
        endcase
    end

    always_ff @(posedge gmii_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            gmii_txen   <= 1'b0;
            gmii_txdata <= 8'h00;
            tx_active   <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            byte_cnt    <= '0;
            pay_cnt     <= '0;
            crc         <= '1;
            last_seen   <= 1'b0;
            ifg_cnt     <= '0;
        end else begin
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            if (need_payload) begin
                if (stream.s_valid) begin
                    gmii_txdata <= stream.s_data;
                    crc         <= crc_next(crc, stream.s_data);
                    pay_cnt     <= pay_cnt_inc;
                    last_seen   <= stream.s_last;
                    state       <= ST_DATA;
                end else begin
                    gmii_txen   <= 1'b0;
                    tx_underrun <= 1'b1;
                    state       <= ST_DRAIN;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (stream.s_valid) begin
                            gmii_txen   <= 1'b1;
                            gmii_txdata <= 8'h55;
                            byte_cnt    <= 4'd1;
                            pay_cnt     <= '0;
                            crc         <= '1;
                            last_seen   <= 1'b0;
                            tx_active   <= 1'b1;
                            state       <= ST_PREAMBLE;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (accept) begin
                            if (byte_cnt == 4'd7) begin
                                gmii_txdata <= 8'hD5;
                                byte_cnt    <= 4'd8;
                            end else begin
                                gmii_txdata <= 8'h55;
                                byte_cnt    <= byte_cnt + 4'd1;
                            end
                        end
                    end
                    // Only reached on accept once the s_last byte is out.
                    ST_DATA, ST_PAD: begin
                        if (accept) begin
                            if (pay_cnt < MIN_LEN) begin
                                gmii_txdata <= 8'h00;
                                crc         <= crc_next(crc, 8'h00);
                                pay_cnt     <= pay_cnt_inc;
                                state       <= ST_PAD;
                            end else begin
                                gmii_txdata <= ~crc[7:0];
                                byte_cnt    <= 4'd1;
                                state       <= ST_FCS;
                            end
                        end
                    end
                    ST_FCS: begin
                        if (accept) begin
                            if (byte_cnt == 4'd4) begin
                                gmii_txen <= 1'b0;
                                tx_done   <= 1'b1;
                                ifg_cnt   <= '0;
                                state     <= ST_IFG;
                            end else begin
                                gmii_txdata <= fcs_byte;
                                byte_cnt    <= byte_cnt + 4'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (stream.s_valid && stream.s_last) begin
                            ifg_cnt <= '0;
                            state   <= ST_IFG;
                        end
                    end
                    ST_IFG: begin
                        if (ifg_cnt == IFG_LAST) begin
                            tx_active <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_tx.sv
// tb_eth_mac_tx: self-checking bench for eth_mac_tx.
// dut0 uses default framing, dut1 uses MIN_FRAME=1 for the CRC check vector.
// Expected wire streams are built from frame rules (preamble, pad, serial
// CRC-32) and compared against every byte the converter model accepts.
module tb_eth_mac_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic [1:0] sv = '0;
    logic [1:0] sl = '0;
    logic [1:0] busy = '0;
    logic [7:0] sd [2];
    logic [1:0] srdy, txen, done, urun, active;
    logic [7:0] txd [2];

    eth_mac_tx_if bus0 ();
    eth_mac_tx_if bus1 ();
    assign bus0.s_valid = sv[0];
    assign bus0.s_data  = sd[0];
    assign bus0.s_last  = sl[0];
    assign srdy[0]      = bus0.s_ready;
    assign bus1.s_valid = sv[1];
    assign bus1.s_data  = sd[1];
    assign bus1.s_last  = sl[1];
    assign srdy[1]      = bus1.s_ready;

    eth_mac_tx #(.MIN_FRAME(60), .IFG_BYTES(12)) dut0 (
        .gmii_clk(clk), .sys_rst(rst), .stream(bus0),
        .gmii_txen(txen[0]), .gmii_txdata(txd[0]), .gmii_txbusy(busy[0]),
        .tx_active(active[0]), .tx_done(done[0]), .tx_underrun(urun[0]));

    eth_mac_tx #(.MIN_FRAME(1), .IFG_BYTES(12)) dut1 (
        .gmii_clk(clk), .sys_rst(rst), .stream(bus1),
        .gmii_txen(txen[1]), .gmii_txdata(txd[1]), .gmii_txbusy(busy[1]),
        .tx_active(active[1]), .tx_done(done[1]), .tx_underrun(urun[1]));

    logic [8:0] src_mem [2][0:2047];
    logic [7:0] exp_mem [2][0:2047];
    logic [7:0] cap     [2][0:2047];
    int         cap_cyc [2][0:2047];
    int         rise_cyc[2][0:63];
    int src_wr[2], src_rd[2], exp_n[2], cap_n[2], chk_pos[2], rise_n[2];
    int done_cnt[2], urun_cnt[2], urun_txen_bad[2], hold_bad[2];
    int busy_mode[2], phase[2], stall_at[2], stall_left[2];
    logic [1:0] prev_txen = '0;
    logic [1:0] prev_acc = '0;
    logic [7:0] prev_txd [2];
    logic [7:0] pay [0:2047];
    int cyc = 0;
    int n_pass = 0, n_total = 0, n_fail = 0;
    int base, d0, u0, r0, bad, gap, len, target, k, n;
    int ends[4];

    always @(posedge clk) cyc <= cyc + 1;

    // Converter busy model + payload source, then monitor after settling.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            phase[d] = (phase[d] + 1) % 4;
            case (busy_mode[d])
                0:       busy[d] = (phase[d] != 3);
                1:       busy[d] = ($urandom_range(0, 2) != 0);
                default: busy[d] = 1'b0;
            endcase
            if (src_rd[d] < src_wr[d] && !(src_rd[d] == stall_at[d] && stall_left[d] > 0)) begin
                sv[d] = 1'b1;
                {sl[d], sd[d]} = src_mem[d][src_rd[d]];
            end else begin
                sv[d] = 1'b0;
                sl[d] = 1'b0;
                sd[d] = 8'h00;
            end
            if (src_rd[d] == stall_at[d] && stall_left[d] > 0) stall_left[d]--;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_txen[d] = 1'b0;
                prev_acc[d]  = 1'b0;
            end else begin
                if (prev_txen[d] && !prev_acc[d] && txd[d] !== prev_txd[d]) hold_bad[d]++;
                if (txen[d] && !prev_txen[d]) begin
                    rise_cyc[d][rise_n[d]] = cyc;
                    rise_n[d]++;
                end
                prev_acc[d] = txen[d] && !busy[d];
                if (prev_acc[d]) begin
                    cap[d][cap_n[d]]     = txd[d];
                    cap_cyc[d][cap_n[d]] = cyc + 1;
                    cap_n[d]++;
                end
                if (sv[d] && srdy[d]) src_rd[d]++;
                if (done[d]) done_cnt[d]++;
                if (urun[d]) begin
                    urun_cnt[d]++;
                    if (txen[d]) urun_txen_bad[d]++;
                end
                prev_txen[d] = txen[d];
                prev_txd[d]  = txd[d];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        exp_mem[d][exp_n[d]] = b;
        exp_n[d]++;
    endtask

    // Serial LFSR form of reflected CRC-32 over expected bytes [from, to).
    task automatic crc_ref(input int d, input int from, input int to, output logic [31:0] c);
        logic [7:0] b;
        logic fb;
        c = 32'hFFFFFFFF;
        for (int i = from; i < to; i++) begin
            b = exp_mem[d][i];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
    endtask

    // Queue pay[0..len-1] at the source and append the expected wire bytes.
    // cut >= 0: only preamble plus the first cut payload bytes go out.
    task automatic add_frame(input int d, input int l, input int minf, input int cut);
        int body;
        logic [31:0] c;
        for (int i = 0; i < l; i++) begin
            src_mem[d][src_wr[d]] = {(i == l - 1), pay[i]};
            src_wr[d]++;
        end
        for (int i = 0; i < 7; i++) push_exp(d, 8'h55);
        push_exp(d, 8'hD5);
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) push_exp(d, pay[i]);
        end else begin
            body = exp_n[d];
            for (int i = 0; i < l; i++) push_exp(d, pay[i]);
            while (exp_n[d] - body < minf) push_exp(d, 8'h00);
            crc_ref(d, body, exp_n[d], c);
            c = ~c;
            for (int i = 0; i < 4; i++) push_exp(d, c[8*i +: 8]);
        end
    endtask

    task automatic wait_idle(input int d, input string tag);
        int w = 0;
        while (w < 20000 && !(cap_n[d] == exp_n[d] && src_rd[d] == src_wr[d] && !active[d] && !txen[d])) begin
            @(negedge clk);
            #2;
            w++;
        end
        check({tag, "_finished"}, (w < 20000) ? 1 : 0, 1);
    endtask

    task automatic cmp_stream(input int d, input string tag);
        for (int i = chk_pos[d]; i < exp_n[d]; i++)
            check($sformatf("%s_byte%0d", tag, i - chk_pos[d]), {24'h0, cap[d][i]}, {24'h0, exp_mem[d][i]});
        check({tag, "_count"}, cap_n[d], exp_n[d]);
        chk_pos[d] = exp_n[d];
    endtask

    task automatic check_reset(input int d, input string tag);
        check({tag, "_txen"}, txen[d], 0);
        check({tag, "_txdata"}, txd[d], 0);
        check({tag, "_ready"}, srdy[d], 0);
        check({tag, "_active"}, active[d], 0);
        check({tag, "_done"}, done[d], 0);
        check({tag, "_underrun"}, urun[d], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            stall_at[d]  = -1;
            busy_mode[d] = 0;
        end
        repeat (3) @(negedge clk);
        #2;
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("idle_txen", txen[0], 0);
        check("idle_ready", srdy[0], 0);

        // 60-byte counting payload, one accept per 4 clocks
        base = exp_n[0]; d0 = done_cnt[0]; r0 = rise_n[0];
        for (int i = 0; i < 60; i++) pay[i] = 8'(i);
        add_frame(0, 60, 60, -1);
        wait_idle(0, "seq60");
        check("seq60_len", cap_n[0] - base, 72);
        bad = 0;
        for (int i = base + 1; i < base + 72; i++)
            if (cap_cyc[0][i] - cap_cyc[0][i-1] != 4) bad++;
        check("seq60_spacing", bad, 0);
        check("seq60_done", done_cnt[0] - d0, 1);
        check("seq60_txen_rises", rise_n[0] - r0, 1);
        cmp_stream(0, "seq60");

        // single-byte payload, padded to minimum
        base = exp_n[0]; d0 = done_cnt[0];
        pay[0] = 8'hAB;
        add_frame(0, 1, 60, -1);
        wait_idle(0, "pad");
        check("pad_len", cap_n[0] - base, 72);
        check("pad_done", done_cnt[0] - d0, 1);
        cmp_stream(0, "pad");

        // four queued random frames, random converter stalls
        busy_mode[0] = 1; d0 = done_cnt[0]; r0 = rise_n[0];
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, 150);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            add_frame(0, len, 60, -1);
            ends[f] = exp_n[0];
        end
        wait_idle(0, "rand");
        cmp_stream(0, "rand");
        check("rand_done", done_cnt[0] - d0, 4);
        for (int f = 1; f < 4; f++) begin
            gap = rise_cyc[0][r0 + f] - cap_cyc[0][ends[f-1] - 1];
            check($sformatf("ifg_gap%0d_ge48", f), (gap >= 48) ? 1 : 0, 1);
        end

        // source stalls before payload byte 10
        busy_mode[0] = 0; d0 = done_cnt[0]; u0 = urun_cnt[0];
        for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
        stall_at[0] = src_wr[0] + 9;
        stall_left[0] = 12;
        add_frame(0, 30, 60, 9);
        wait_idle(0, "urun");
        cmp_stream(0, "urun");
        check("urun_pulse", urun_cnt[0] - u0, 1);
        check("urun_no_done", done_cnt[0] - d0, 0);
        check("urun_txen_low", urun_txen_bad[0], 0);
        len = 45;
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
        add_frame(0, len, 60, -1);
        wait_idle(0, "after_urun");
        cmp_stream(0, "after_urun");
        check("after_urun_done", done_cnt[0] - d0, 1);

        // reset while FCS byte 2 is on the wire
        base = exp_n[0]; d0 = done_cnt[0];
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
        add_frame(0, 20, 60, -1);
        target = base + 8 + 60 + 2;
        exp_n[0] = target;
        k = 0;
        while (k < 5000 && cap_n[0] < target) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("fcs1_reached", (k < 5000) ? 1 : 0, 1);
        check("active_mid_frame", active[0], 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_reset(0, "midrst");
        cmp_stream(0, "midrst");
        check("midrst_no_done", done_cnt[0] - d0, 0);
        len = 70;
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
        add_frame(0, len, 60, -1);
        rst = 1'b0;
        wait_idle(0, "post_rst");
        cmp_stream(0, "post_rst");
        check("post_rst_done", done_cnt[0] - d0, 1);

        // CRC check vector "123456789" with MIN_FRAME=1
        busy_mode[1] = 1;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        add_frame(1, 9, 1, -1);
        wait_idle(1, "crc");
        cmp_stream(1, "crc");
        n = cap_n[1];
        check("crc_len", n, 21);
        check("crc_fcs0", cap[1][n-4], 32'h26);
        check("crc_fcs1", cap[1][n-3], 32'h39);
        check("crc_fcs2", cap[1][n-2], 32'hF4);
        check("crc_fcs3", cap[1][n-1], 32'hCB);
        check("crc_done", done_cnt[1], 1);

        check("hold0", hold_bad[0], 0);
        check("hold1", hold_bad[1], 0);
        check("urun1_none", urun_cnt[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
